// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and defaults for the
// multi-port register file.
package regfile_pkg;

  typedef enum logic {
    RF_CLEAR,
    RF_READY
  } rf_state_t;

  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int N_RD_DEF     = 2;
  localparam int BYPASS_DEF   = 1;
  localparam int ZERO_REG_DEF = 1;
  localparam int IO_REG_DEF   = 1;
  localparam int IO_W_DEF     = 3;
  localparam int DBG_W_DEF    = 16;

  function automatic int slice_w(
    input int data_w,
    input int dbg_w
  );
    return ((data_w / dbg_w) > 1) ?
      $clog2(data_w / dbg_w) : 1;
  endfunction

endpackage

// File: rtl/regfile_mp_read_port.sv
// rf_read_port: zero/bypass/array select
// feeding one registered read port.
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int BYPASS   = BYPASS_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ready,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] arr_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] nxt;

  always_comb begin
    nxt = arr_data;
    if (ZERO_REG != 0 && addr == '0) begin
      nxt = '0;
    end else if (BYPASS != 0 && wr_en &&
                 addr == wr_addr) begin
      nxt = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data <= '0;
    end else if (ready) begin
      data <= nxt;
    end else begin
      data <= '0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file
// with clear engine, IO-mapped register and debug port.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int N_RD     = N_RD_DEF,
  parameter int BYPASS   = BYPASS_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF,
  parameter int IO_REG   = IO_REG_DEF,
  parameter int IO_W     = IO_W_DEF,
  parameter int DBG_W    = DBG_W_DEF,
  localparam int SL_W    = slice_w(DATA_W, DBG_W)
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   RegW,
  input  logic [ADDR_W-1:0]      DR,
  input  logic [DATA_W-1:0]      Reg_In,
  input  logic [N_RD*ADDR_W-1:0] SR,
  output logic [N_RD*DATA_W-1:0] ReadReg,
  input  logic [IO_W-1:0]        IO_In,
  input  logic [ADDR_W-1:0]      Dbg_Addr,
  input  logic [SL_W-1:0]        Dbg_Slice,
  output logic [DBG_W-1:0]       Dbg_Value,
  output logic                   Busy
);

  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int N_SLICE = DATA_W / DBG_W;
  localparam logic [ADDR_W-1:0] IO_A =
    ADDR_W'(IO_REG);

  logic [DATA_W-1:0] mem [DEPTH];

  rf_state_t         state;
  logic [ADDR_W-1:0] ptr;
  logic              ready;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] dbg_word;
  logic [DBG_W-1:0]  dbg_next;

  assign ready = (state == RF_READY);

  assign wr_en = RegW && ready &&
    !(ZERO_REG != 0 && DR == '0);

  // IO bits always win over a same-cycle write
  always_comb begin
    wr_data = Reg_In;
    if (DR == IO_A) begin
      wr_data[IO_W-1:0] = IO_In;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= RF_CLEAR;
      ptr   <= '0;
      Busy  <= 1'b1;
    end else begin
      unique case (state)
        RF_CLEAR: begin
          ptr <= ptr + ADDR_W'(1);
          if (&ptr) begin
            state <= RF_READY;
            Busy  <= 1'b0;
          end
        end
        RF_READY: begin
          Busy <= 1'b0;
        end
        default: begin
          state <= RF_CLEAR;
        end
      endcase
    end
  end

  // No reset on the array so it stays RAM-inferable
  always_ff @(posedge CLK) begin
    if (RST_N) begin
      if (!ready) begin
        mem[ptr] <= '0;
      end else begin
        if (wr_en) begin
          mem[DR] <= wr_data;
        end
        mem[IO_A][IO_W-1:0] <= IO_In;
      end
    end
  end

  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    rf_read_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .BYPASS  (BYPASS),
      .ZERO_REG(ZERO_REG)
    ) u_rd (
      .clk     (CLK),
      .rst_n   (RST_N),
      .ready   (ready),
      .addr    (SR[k*ADDR_W +: ADDR_W]),
      .arr_data(mem[SR[k*ADDR_W +: ADDR_W]]),
      .wr_en   (wr_en),
      .wr_addr (DR),
      .wr_data (wr_data),
      .data    (ReadReg[k*DATA_W +: DATA_W])
    );
  end

  assign dbg_word = mem[Dbg_Addr];

  always_comb begin
    dbg_next = '0;
    for (int s = 0; s < N_SLICE; s++) begin
      if (Dbg_Slice == SL_W'(s)) begin
        dbg_next = dbg_word[s*DBG_W +: DBG_W];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      Dbg_Value <= '0;
    end else if (ready) begin
      Dbg_Value <= dbg_next;
    end else begin
      Dbg_Value <= '0;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp,
// default build plus a BYPASS=0 build on shared inputs.
module tb_regfile_mp;

  localparam int SRC_RD0 = 0;
  localparam int SRC_RD1 = 1;
  localparam int SRC_NB0 = 2;
  localparam int SRC_NB1 = 3;
  localparam int SRC_DBG = 4;
  localparam int SRC_BSY = 5;

  typedef struct {
    string       tag;
    int          src;
    logic [31:0] exp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reg_w;
  logic [4:0]  dr;
  logic [31:0] reg_in;
  logic [9:0]  sr;
  logic [2:0]  io_in;
  logic [4:0]  dbg_addr;
  logic [0:0]  dbg_slice;
  logic [63:0] read_reg;
  logic [15:0] dbg_value;
  logic        busy;
  logic [63:0] read_nb;
  logic [15:0] dbg_nb;
  logic        busy_nb;

  exp_t        sb[$];
  logic [31:0] model [32];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  regfile_mp dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .RegW     (reg_w),
    .DR       (dr),
    .Reg_In   (reg_in),
    .SR       (sr),
    .ReadReg  (read_reg),
    .IO_In    (io_in),
    .Dbg_Addr (dbg_addr),
    .Dbg_Slice(dbg_slice),
    .Dbg_Value(dbg_value),
    .Busy     (busy)
  );

  regfile_mp #(.BYPASS(0)) dut_nb (
    .CLK      (clk),
    .RST_N    (rst_n),
    .RegW     (reg_w),
    .DR       (dr),
    .Reg_In   (reg_in),
    .SR       (sr),
    .ReadReg  (read_nb),
    .IO_In    (io_in),
    .Dbg_Addr (dbg_addr),
    .Dbg_Slice(dbg_slice),
    .Dbg_Value(dbg_nb),
    .Busy     (busy_nb)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sample(
    input int src
  );
    case (src)
      SRC_RD0: return read_reg[31:0];
      SRC_RD1: return read_reg[63:32];
      SRC_NB0: return read_nb[31:0];
      SRC_NB1: return read_nb[63:32];
      SRC_DBG: return {16'h0, dbg_value};
      default: return {31'h0, busy};
    endcase
  endfunction

  task automatic push(
    input string       tag,
    input int          src,
    input logic [31:0] exp
  );
    exp_t e;
    e.tag = tag;
    e.src = src;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, sample(e.src), e.exp);
    end
  endtask

  // One ready-state cycle with expectations from the model
  task automatic op(
    input string       tag,
    input logic        we,
    input logic [4:0]  w_a,
    input logic [31:0] din,
    input logic [4:0]  a0,
    input logic [4:0]  a1,
    input logic [2:0]  io,
    input logic [4:0]  d_a,
    input logic [0:0]  d_s
  );
    logic [31:0] wv;
    logic [31:0] dw;
    logic [4:0]  a;
    logic [31:0] e_bp;
    logic [31:0] e_nb;
    reg_w     = we;
    dr        = w_a;
    reg_in    = din;
    sr        = {a1, a0};
    io_in     = io;
    dbg_addr  = d_a;
    dbg_slice = d_s;
    wv = din;
    if (w_a == 5'd1) wv[2:0] = io;
    for (int p = 0; p < 2; p++) begin
      a = (p == 0) ? a0 : a1;
      e_nb = (a == 5'd0) ? 32'h0 : model[a];
      e_bp = e_nb;
      if (a != 5'd0 && we && a == w_a) e_bp = wv;
      push({tag, "_bp", (p == 0) ? "0" : "1"},
           (p == 0) ? SRC_RD0 : SRC_RD1, e_bp);
      push({tag, "_nb", (p == 0) ? "0" : "1"},
           (p == 0) ? SRC_NB0 : SRC_NB1, e_nb);
    end
    dw = model[d_a];
    push({tag, "_dbg"}, SRC_DBG,
         d_s ? {16'h0, dw[31:16]} : {16'h0, dw[15:0]});
    cyc();
    if (we && w_a != 5'd0) model[w_a] = wv;
    model[1][2:0] = io;
  endtask

  task automatic reset_and_clear(
    input string tag,
    input int    pre_cycles
  );
    int cnt;
    rst_n = 1'b0;
    push({tag, "_busy0"}, SRC_BSY, 32'h1);
    push({tag, "_rd0"}, SRC_RD0, 32'h0);
    push({tag, "_dbg0"}, SRC_DBG, 32'h0);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < pre_cycles; i++) cyc();
    if (pre_cycles > 0) begin
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
    end
    cnt = 1;
    reg_w  = 1'b1;
    dr     = 5'd3;
    reg_in = 32'hCAFEF00D;
    io_in  = 3'b111;
    for (int i = 0; i < 100; i++) begin
      push({tag, "_clr_rd"}, SRC_RD1, 32'h0);
      cyc();
      if (busy) cnt++;
      else break;
    end
    chk({tag, "_busy_len"}, cnt, 32);
    reg_w = 1'b0;
    io_in = 3'b000;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  task automatic scan(input string tag);
    for (int i = 0; i < 32; i++) begin
      op(tag, 1'b0, 5'd0, 32'h0, 5'(i), 5'(i),
         3'b000, 5'(i), 1'(i & 1));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    reg_w     = 1'b0;
    dr        = '0;
    reg_in    = '0;
    sr        = '0;
    io_in     = '0;
    dbg_addr  = '0;
    dbg_slice = '0;

    reset_and_clear("clr", 0);
    scan("scan0");

    op("wr5", 1'b1, 5'd5, 32'hDEADBEEF,
       5'd0, 5'd0, 3'b000, 5'd0, 1'b0);
    op("rd5", 1'b0, 5'd0, 32'h0,
       5'd5, 5'd5, 3'b000, 5'd5, 1'b1);
    op("wr0", 1'b1, 5'd0, 32'h00001234,
       5'd0, 5'd0, 3'b000, 5'd0, 1'b0);
    op("rd0", 1'b0, 5'd0, 32'h0,
       5'd0, 5'd0, 3'b000, 5'd0, 1'b0);
    op("byp7", 1'b1, 5'd7, 32'hA5A5A5A5,
       5'd5, 5'd7, 3'b000, 5'd7, 1'b0);
    op("rd7", 1'b0, 5'd0, 32'h0,
       5'd7, 5'd7, 3'b000, 5'd7, 1'b1);
    op("io_wr", 1'b1, 5'd1, 32'hFFFFFFF0,
       5'd0, 5'd0, 3'b101, 5'd0, 1'b0);
    op("io_a", 1'b0, 5'd0, 32'h0,
       5'd1, 5'd1, 3'b010, 5'd1, 1'b0);
    op("io_b", 1'b0, 5'd0, 32'h0,
       5'd1, 5'd1, 3'b010, 5'd1, 1'b0);
    op("io_byp", 1'b1, 5'd1, 32'h12345678,
       5'd1, 5'd1, 3'b111, 5'd1, 1'b0);
    op("io_c", 1'b0, 5'd0, 32'h0,
       5'd1, 5'd0, 3'b111, 5'd1, 1'b1);
    op("dbg_wr", 1'b1, 5'd2, 32'h89ABCDEF,
       5'd2, 5'd0, 3'b000, 5'd0, 1'b0);
    op("dbg_s0", 1'b0, 5'd0, 32'h0,
       5'd2, 5'd2, 3'b000, 5'd2, 1'b0);
    op("dbg_s1", 1'b0, 5'd0, 32'h0,
       5'd0, 5'd2, 3'b000, 5'd2, 1'b1);

    for (int i = 0; i < 60; i++) begin
      op("rnd", 1'($urandom_range(0, 1)),
         5'($urandom_range(0, 31)),
         $urandom(),
         5'($urandom_range(0, 31)),
         5'($urandom_range(0, 31)),
         3'($urandom_range(0, 7)),
         5'($urandom_range(0, 31)),
         1'($urandom_range(0, 1)));
    end
    scan("scan1");

    reset_and_clear("mid", 10);
    scan("scan2");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
